mux_8x1_rr_sched: RTL

- Round-robin scheduler that shares one 8:1 mux output among 8 requesters.
- Drives the mux select lines (S2..S0) and a one-hot grant back to the requesters.
- Sits directly in front of the mux_8X1 datapath. The mux stays purely combinational; all sequencing and fairness live here.
- Each grant is held while the requester keeps asking, capped at MAX_HOLD cycles when others are waiting.

---
 rtl/mux_8x1_rr_sched_pkg.sv | 22 ++
 rtl/mux_8x1_rr_sched_if.sv | 24 ++
 rtl/mux_8x1_rr_sched_rr_pick.sv | 26 ++
 rtl/mux_8x1_rr_sched.sv | 102 ++++++++++
 4 files changed

// File: rtl/mux_8x1_rr_sched_pkg.sv
// Shared constants, state encoding and helpers for the 8:1 mux round-robin scheduler.
package mux_sched_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_e;

  // Grant vectors are one-hot or zero, so OR-ing the set indices gives the index.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_8x1_rr_sched_if.sv
// Requester-side bundle of the scheduler: level requests in, grant/select/hold out.
// Handshake: req[i] is a level held by requester i; it owns the mux output on every
// cycle where gnt[i] is high, and sel_valid/sel/gnt all change on the same clk edge.
interface mux_sched_if;
  import mux_sched_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic               sel_valid;
  logic [3:0]         hold_cnt;
  sched_state_e       state_dbg;

  modport master (
    output req,
    input  gnt, sel, sel_valid, hold_cnt, state_dbg
  );

  modport slave (
    input  req,
    output gnt, sel, sel_valid, hold_cnt, state_dbg
  );

endinterface

// File: rtl/mux_8x1_rr_sched_rr_pick.sv
// Rotating priority encoder: first set req bit scanning upward from start, wrapping 7->0.
module rr_pick
  import mux_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   start,
  output logic [SEL_W-1:0]   win,
  output logic               any
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = SEL_W'(int'(start) + i);
      if (!any && req[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_8x1_rr_sched.sv
// Round-robin scheduler for the 8:1 mux: registered one-hot grant, matching select,
// and a hold counter that caps ownership at MAX_HOLD cycles while others wait.
module mux_8x1_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_sched_if.slave  bus
);

  sched_state_e       state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic [SEL_W-1:0]   owner;
  logic [NUM_REQ-1:0] pick_req;
  logic [SEL_W-1:0]   pick_start;
  logic [SEL_W-1:0]   win;
  logic               any;
  logic               take_new;

  assign owner = onehot_to_idx(gnt_q);

  // Masking the owner out means a scan from owner+1 only ever finds other requesters.
  assign pick_req   = bus.req & ~gnt_q;
  assign pick_start = (state_q == IDLE) ? ptr_q + SEL_W'(1) : owner + SEL_W'(1);

  rr_pick u_pick (
    .req   (pick_req),
    .start (pick_start),
    .win   (win),
    .any   (any)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    take_new = 1'b0;

    case (state_q)
      IDLE: begin
        if (any) take_new = 1'b1;
      end
      GRANT: begin
        if (!bus.req[owner]) begin
          if (any) begin
            take_new = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end else if (hold_q == HOLD_W'(MAX_HOLD)) begin
          if (any) take_new = 1'b1;
          else     hold_d   = HOLD_W'(1);
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_new) begin
      state_d = GRANT;
      gnt_d   = NUM_REQ'(1) << win;
      sel_d   = win;
      hold_d  = HOLD_W'(1);
      ptr_d   = win;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= SEL_W'(NUM_REQ - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.sel_valid = (state_q == GRANT);
  assign bus.hold_cnt  = hold_q;
  assign bus.state_dbg = state_q;

endmodule
